// File: rtl/sync_fifo_prog.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_prog
// Description : Single-clock FIFO with standard or first-word-fall-through
//               read, programmable almost-full/almost-empty thresholds,
//               sticky overflow/underflow flags and synchronous flush.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_prog #(
  parameter int DATA_WIDTH  = 16,
  parameter int DEPTH_WIDTH = 11,
  parameter bit FWFT        = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   wr_en,
  input  logic [DATA_WIDTH-1:0]  wr_data,
  output logic                   wr_full,
  input  logic                   rd_en,
  output logic [DATA_WIDTH-1:0]  rd_data,
  output logic                   rd_valid,
  output logic                   rd_empty,
  input  logic [DEPTH_WIDTH:0]   af_thresh,
  input  logic [DEPTH_WIDTH:0]   ae_thresh,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [DEPTH_WIDTH:0]   water_level,
  output logic                   overflow,
  output logic                   underflow,
  input  logic                   clr_flags
);

  localparam int                 c_cap     = 1 << DEPTH_WIDTH;
  localparam logic [DEPTH_WIDTH:0] c_cap_lvl = {1'b1, {DEPTH_WIDTH{1'b0}}};

  logic [DATA_WIDTH-1:0] r_mem [c_cap];
  logic [DEPTH_WIDTH:0]  r_wp;
  logic [DEPTH_WIDTH:0]  r_rp;
  logic [DEPTH_WIDTH:0]  w_ram_level;
  logic [DEPTH_WIDTH:0]  w_level;
  logic                  w_full;
  logic                  w_rd_empty;
  logic                  w_wr_acc;
  logic                  w_ovf_evt;
  logic                  w_unf_evt;
  logic                  r_ovf;
  logic                  r_unf;

  // Pointers carry one extra wrap bit, so the difference is the exact word count.
  assign w_ram_level = r_wp - r_rp;
  assign w_full      = (w_level == c_cap_lvl);
  assign w_wr_acc    = wr_en & ~w_full & ~flush;
  assign w_ovf_evt   = wr_en & w_full & ~flush;
  assign w_unf_evt   = rd_en & w_rd_empty & ~flush;

  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wp[DEPTH_WIDTH-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp <= '0;
    end else if (flush) begin
      r_wp <= '0;
    end else if (w_wr_acc) begin
      r_wp <= r_wp + 1'b1;
    end
  end

  // A set event in the same cycle as clr_flags leaves the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else if (!flush) begin
      r_ovf <= w_ovf_evt | (r_ovf & ~clr_flags);
      r_unf <= w_unf_evt | (r_unf & ~clr_flags);
    end
  end

  generate
    if (FWFT) begin : g_fwft
      // Two-stage prefetch: RAM -> r_q_* -> presented output register.
      logic [DATA_WIDTH-1:0] r_q_data;
      logic [DATA_WIDTH-1:0] r_out_data;
      logic                  r_q_valid;
      logic                  r_out_valid;
      logic                  w_pop;
      logic                  w_out_load;
      logic                  w_move;
      logic                  w_ram_rd;

      assign w_pop      = rd_en & r_out_valid & ~flush;
      assign w_out_load = ~r_out_valid | w_pop;
      assign w_move     = w_out_load & r_q_valid;
      assign w_ram_rd   = (~r_q_valid | w_move) & (w_ram_level != '0);

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_rp        <= '0;
          r_q_data    <= '0;
          r_q_valid   <= 1'b0;
          r_out_data  <= '0;
          r_out_valid <= 1'b0;
        end else if (flush) begin
          r_rp        <= '0;
          r_q_valid   <= 1'b0;
          r_out_valid <= 1'b0;
        end else begin
          if (w_move) begin
            r_out_data <= r_q_data;
          end
          if (w_out_load) begin
            r_out_valid <= r_q_valid;
          end
          if (w_ram_rd) begin
            r_q_data <= r_mem[r_rp[DEPTH_WIDTH-1:0]];
            r_rp     <= r_rp + 1'b1;
          end
          r_q_valid <= w_ram_rd | (r_q_valid & ~w_move);
        end
      end

      assign w_level    = w_ram_level
                        + {{DEPTH_WIDTH{1'b0}}, r_q_valid}
                        + {{DEPTH_WIDTH{1'b0}}, r_out_valid};
      assign w_rd_empty = ~r_out_valid;
      assign rd_data    = r_out_data;
      assign rd_valid   = r_out_valid;
    end else begin : g_std
      logic [DATA_WIDTH-1:0] r_out_data;
      logic                  r_out_valid;
      logic                  w_rd_acc;

      assign w_rd_empty = (w_ram_level == '0);
      assign w_rd_acc   = rd_en & ~w_rd_empty & ~flush;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_rp        <= '0;
          r_out_data  <= '0;
          r_out_valid <= 1'b0;
        end else if (flush) begin
          r_rp        <= '0;
          r_out_valid <= 1'b0;
        end else begin
          r_out_valid <= w_rd_acc;
          if (w_rd_acc) begin
            r_out_data <= r_mem[r_rp[DEPTH_WIDTH-1:0]];
            r_rp       <= r_rp + 1'b1;
          end
        end
      end

      assign w_level  = w_ram_level;
      assign rd_data  = r_out_data;
      assign rd_valid = r_out_valid;
    end
  endgenerate

  assign wr_full      = w_full;
  assign rd_empty     = w_rd_empty;
  assign water_level  = w_level;
  assign almost_full  = (w_level >= af_thresh);
  assign almost_empty = (w_level <= ae_thresh);
  assign overflow     = r_ovf;
  assign underflow    = r_unf;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_prog.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_fifo_prog
// Description : Bench for sync_fifo_prog, standard and FWFT instances driven
//               with the same stimulus and checked against queue models.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_prog;

  localparam int DW  = 16;
  localparam int AW  = 4;
  localparam int CAP = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          wr_en;
  logic          rd_en;
  logic          clr_flags;
  logic [DW-1:0] wr_data;
  logic [AW:0]   af_thresh;
  logic [AW:0]   ae_thresh;

  logic          s_wr_full, s_rd_valid, s_rd_empty, s_af, s_ae, s_ovf, s_unf;
  logic [DW-1:0] s_rd_data;
  logic [AW:0]   s_level;
  logic          f_wr_full, f_rd_valid, f_rd_empty, f_af, f_ae, f_ovf, f_unf;
  logic [DW-1:0] f_rd_data;
  logic [AW:0]   f_level;

  always #5 clk = ~clk;

  sync_fifo_prog #(.DATA_WIDTH(DW), .DEPTH_WIDTH(AW), .FWFT(1'b0)) u_std (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
    .wr_full(s_wr_full), .rd_en(rd_en), .rd_data(s_rd_data), .rd_valid(s_rd_valid),
    .rd_empty(s_rd_empty), .af_thresh(af_thresh), .ae_thresh(ae_thresh),
    .almost_full(s_af), .almost_empty(s_ae), .water_level(s_level),
    .overflow(s_ovf), .underflow(s_unf), .clr_flags(clr_flags)
  );

  sync_fifo_prog #(.DATA_WIDTH(DW), .DEPTH_WIDTH(AW), .FWFT(1'b1)) u_fwft (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
    .wr_full(f_wr_full), .rd_en(rd_en), .rd_data(f_rd_data), .rd_valid(f_rd_valid),
    .rd_empty(f_rd_empty), .af_thresh(af_thresh), .ae_thresh(ae_thresh),
    .almost_full(f_af), .almost_empty(f_ae), .water_level(f_level),
    .overflow(f_ovf), .underflow(f_unf), .clr_flags(clr_flags)
  );

  // Reference model: each stored word remembers the edge that wrote it.
  // FWFT rule: the head word is presented once two edges have passed since its write.
  typedef struct { logic [DW-1:0] d; int e; } ent_t;
  ent_t          q_s[$];
  ent_t          q_f[$];
  logic [DW-1:0] ms_rdata, mf_rdata;
  bit            ms_rv, ms_ovf, ms_unf, mf_ovf, mf_unf;
  int            edge_n;
  int            n_chk;
  int            n_err;

  typedef struct {
    bit          wr, rd;
    logic [DW-1:0] wd;
    int          lvl;
    bit          full, empty, rv;
    logic [DW-1:0] rdat;
    bit          ovf, unf, ae, af;
  } vec_t;
  vec_t vt[34];

  function automatic bit f_vis();
    return (q_f.size() > 0) && (q_f[0].e + 2 <= edge_n);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q_s.delete();
    q_f.delete();
    ms_rdata = '0;
    mf_rdata = '0;
    ms_rv    = 1'b0;
    ms_ovf   = 1'b0;
    ms_unf   = 1'b0;
    mf_ovf   = 1'b0;
    mf_unf   = 1'b0;
  endtask

  task automatic model_edge();
    bit   vis, s_full, s_empty, f_full;
    ent_t e, t;
    vis     = f_vis();
    s_full  = (q_s.size() == CAP);
    s_empty = (q_s.size() == 0);
    f_full  = (q_f.size() == CAP);
    edge_n++;
    e.d = wr_data;
    e.e = edge_n;
    if (flush) begin
      q_s.delete();
      q_f.delete();
      ms_rv = 1'b0;
    end else begin
      ms_rv = rd_en && !s_empty;
      if (ms_rv) begin
        t = q_s.pop_front();
        ms_rdata = t.d;
      end
      if (wr_en && !s_full) q_s.push_back(e);
      ms_ovf = (wr_en && s_full)  || (ms_ovf && !clr_flags);
      ms_unf = (rd_en && s_empty) || (ms_unf && !clr_flags);
      if (rd_en && vis) t = q_f.pop_front();
      if (wr_en && !f_full) q_f.push_back(e);
      mf_ovf = (wr_en && f_full) || (mf_ovf && !clr_flags);
      mf_unf = (rd_en && !vis)   || (mf_unf && !clr_flags);
    end
    if (f_vis()) mf_rdata = q_f[0].d;
  endtask

  task automatic check_all();
    int ls, lf;
    bit vis;
    ls  = q_s.size();
    lf  = q_f.size();
    vis = f_vis();
    chk("s_level", 32'(s_level),    32'(ls));
    chk("s_full",  32'(s_wr_full),  32'(ls == CAP));
    chk("s_empty", 32'(s_rd_empty), 32'(ls == 0));
    chk("s_valid", 32'(s_rd_valid), 32'(ms_rv));
    chk("s_data",  32'(s_rd_data),  32'(ms_rdata));
    chk("s_ovf",   32'(s_ovf),      32'(ms_ovf));
    chk("s_unf",   32'(s_unf),      32'(ms_unf));
    chk("s_af",    32'(s_af),       32'(ls >= int'(af_thresh)));
    chk("s_ae",    32'(s_ae),       32'(ls <= int'(ae_thresh)));
    chk("f_level", 32'(f_level),    32'(lf));
    chk("f_full",  32'(f_wr_full),  32'(lf == CAP));
    chk("f_empty", 32'(f_rd_empty), 32'(!vis));
    chk("f_valid", 32'(f_rd_valid), 32'(vis));
    chk("f_data",  32'(f_rd_data),  32'(mf_rdata));
    chk("f_ovf",   32'(f_ovf),      32'(mf_ovf));
    chk("f_unf",   32'(f_unf),      32'(mf_unf));
    chk("f_af",    32'(f_af),       32'(lf >= int'(af_thresh)));
    chk("f_ae",    32'(f_ae),       32'(lf <= int'(ae_thresh)));
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else     model_edge();
    #1;
    check_all();
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_s_level"}, 32'(s_level),    32'd0);
    chk({tag, "_s_empty"}, 32'(s_rd_empty), 32'd1);
    chk({tag, "_s_full"},  32'(s_wr_full),  32'd0);
    chk({tag, "_s_valid"}, 32'(s_rd_valid), 32'd0);
    chk({tag, "_s_data"},  32'(s_rd_data),  32'd0);
    chk({tag, "_s_ovf"},   32'(s_ovf),      32'd0);
    chk({tag, "_f_level"}, 32'(f_level),    32'd0);
    chk({tag, "_f_empty"}, 32'(f_rd_empty), 32'd1);
    chk({tag, "_f_valid"}, 32'(f_rd_valid), 32'd0);
    chk({tag, "_f_data"},  32'(f_rd_data),  32'd0);
    chk({tag, "_f_unf"},   32'(f_unf),      32'd0);
  endtask

  initial begin
    int wp;
    n_chk = 0;
    n_err = 0;
    edge_n = 0;

    // Ramp-up/ramp-down vectors for the standard-mode instance, af=12 ae=3.
    for (int i = 0; i < 17; i++) begin
      vt[i].wr = 1'b1; vt[i].rd = 1'b0; vt[i].wd = DW'(i);
      vt[i].lvl = (i + 1 > CAP) ? CAP : i + 1;
      vt[i].full = (vt[i].lvl == CAP); vt[i].empty = 1'b0;
      vt[i].rv = 1'b0; vt[i].rdat = '0;
      vt[i].ovf = (i == 16); vt[i].unf = 1'b0;
      vt[i].ae = (vt[i].lvl <= 3); vt[i].af = (vt[i].lvl >= 12);
    end
    for (int j = 0; j < 17; j++) begin
      vt[17+j].wr = 1'b0; vt[17+j].rd = 1'b1; vt[17+j].wd = '0;
      vt[17+j].lvl = (j + 1 > CAP) ? 0 : CAP - (j + 1);
      vt[17+j].full = 1'b0; vt[17+j].empty = (vt[17+j].lvl == 0);
      vt[17+j].rv = (j < CAP); vt[17+j].rdat = (j < CAP) ? DW'(j) : DW'(15);
      vt[17+j].ovf = 1'b1; vt[17+j].unf = (j == 16);
      vt[17+j].ae = (vt[17+j].lvl <= 3); vt[17+j].af = (vt[17+j].lvl >= 12);
    end

    rst = 1'b1; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; clr_flags = 1'b0;
    wr_data = '0; af_thresh = 5'd12; ae_thresh = 5'd3;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_reset_values("reset");
    check_all();
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 34; i++) begin
      wr_en = vt[i].wr; rd_en = vt[i].rd; wr_data = vt[i].wd;
      tick();
      chk($sformatf("tbl%0d_level", i), 32'(s_level),    32'(vt[i].lvl));
      chk($sformatf("tbl%0d_full", i),  32'(s_wr_full),  32'(vt[i].full));
      chk($sformatf("tbl%0d_empty", i), 32'(s_rd_empty), 32'(vt[i].empty));
      chk($sformatf("tbl%0d_valid", i), 32'(s_rd_valid), 32'(vt[i].rv));
      chk($sformatf("tbl%0d_data", i),  32'(s_rd_data),  32'(vt[i].rdat));
      chk($sformatf("tbl%0d_ovf", i),   32'(s_ovf),      32'(vt[i].ovf));
      chk($sformatf("tbl%0d_unf", i),   32'(s_unf),      32'(vt[i].unf));
      chk($sformatf("tbl%0d_ae", i),    32'(s_ae),       32'(vt[i].ae));
      chk($sformatf("tbl%0d_af", i),    32'(s_af),       32'(vt[i].af));
    end
    wr_en = 1'b0; rd_en = 1'b0;

    clr_flags = 1'b1; tick(); clr_flags = 1'b0;
    chk("clr_s_ovf", 32'(s_ovf), 32'd0);
    chk("clr_s_unf", 32'(s_unf), 32'd0);
    flush = 1'b1; tick(); flush = 1'b0;

    // FWFT latency: write at edge k, presented after edge k+2.
    wr_en = 1'b1; wr_data = 16'hA5A5; tick();
    wr_en = 1'b0; tick();
    chk("fwft_k1_valid", 32'(f_rd_valid), 32'd0);
    tick();
    chk("fwft_k2_valid", 32'(f_rd_valid), 32'd1);
    chk("fwft_k2_data",  32'(f_rd_data),  32'hA5A5);
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    chk("fwft_pop_empty", 32'(f_rd_empty), 32'd1);
    chk("fwft_pop_level", 32'(f_level),    32'd0);
    chk("std_rd_valid",   32'(s_rd_valid), 32'd1);
    chk("std_rd_data",    32'(s_rd_data),  32'hA5A5);

    // Full FIFO with simultaneous write/read and clr_flags: read wins, overflow set.
    for (int i = 0; i < CAP; i++) begin
      wr_en = 1'b1; wr_data = DW'(100 + i); tick();
    end
    chk("full_s", 32'(s_wr_full), 32'd1);
    chk("full_f", 32'(f_wr_full), 32'd1);
    wr_en = 1'b1; rd_en = 1'b1; clr_flags = 1'b1; wr_data = 16'hDEAD; tick();
    wr_en = 1'b0; rd_en = 1'b0; clr_flags = 1'b0;
    chk("fullrw_s_level", 32'(s_level), 32'd15);
    chk("fullrw_s_ovf",   32'(s_ovf),   32'd1);
    chk("fullrw_s_data",  32'(s_rd_data), 32'd100);
    chk("fullrw_f_level", 32'(f_level), 32'd15);
    chk("fullrw_f_ovf",   32'(f_ovf),   32'd1);

    // Flush at level 9 with wr_en/rd_en asserted.
    flush = 1'b1; tick(); flush = 1'b0;
    for (int i = 0; i < 9; i++) begin
      wr_en = 1'b1; wr_data = DW'(200 + i); tick();
    end
    chk("pre_flush_level", 32'(s_level), 32'd9);
    flush = 1'b1; wr_en = 1'b1; rd_en = 1'b1; tick();
    flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    chk("flush_s_level", 32'(s_level),    32'd0);
    chk("flush_s_empty", 32'(s_rd_empty), 32'd1);
    chk("flush_f_level", 32'(f_level),    32'd0);
    chk("flush_f_empty", 32'(f_rd_empty), 32'd1);
    chk("flush_s_ovf",   32'(s_ovf),      32'd1);

    // Threshold extremes.
    af_thresh = 5'd0; ae_thresh = 5'd16; tick();
    chk("af0_s", 32'(s_af), 32'd1);
    for (int i = 0; i < CAP; i++) begin
      wr_en = 1'b1; wr_data = DW'(i * 3); tick();
    end
    wr_en = 1'b0;
    chk("ae16_s", 32'(s_ae), 32'd1);
    chk("ae16_f", 32'(f_ae), 32'd1);
    flush = 1'b1; tick(); flush = 1'b0;
    af_thresh = 5'd12; ae_thresh = 5'd3;

    // Asynchronous reset in the middle of a burst.
    for (int i = 0; i < 6; i++) begin
      wr_en = 1'b1; rd_en = (i % 2 == 1); wr_data = DW'(16'h3000 + i); tick();
    end
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk_reset_values("midrst");
    check_all();
    @(negedge clk);
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;

    // Randomized traffic with phases favouring fill, balance and drain.
    for (int c = 0; c < 3000; c++) begin
      if (c % 100 == 0) begin
        af_thresh = 5'($urandom_range(0, 17));
        ae_thresh = 5'($urandom_range(0, 17));
      end
      case ((c / 250) % 3)
        0:       wp = 80;
        1:       wp = 50;
        default: wp = 20;
      endcase
      wr_en     = ($urandom_range(0, 99) < wp);
      rd_en     = ($urandom_range(0, 99) < 100 - wp);
      flush     = ($urandom_range(0, 199) == 0);
      clr_flags = ($urandom_range(0, 49) == 0);
      wr_data   = DW'($urandom);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
